pic_inta_sequencer: RTL and testbench

- Clocked interrupt-acknowledge engine for the 8259A-style PIC.
- Sits downstream of the priority resolver and upstream of the data bus buffer.
- Raises INT for the winning request, counts the CPU's INTA pulses and tells the ISR/IRR which level to set and clear.
- Drives the vector or CALL bytes onto the bus through the buffer, and issues the automatic EOI.

---
 rtl/pic_inta_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_inta_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259A-style PIC: raises INT, tracks the
// CPU's INTA pulses, drives CALL/vector bytes and issues set/clear/AEOI pulses.
module pic_inta_sequencer #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] SPUR_LEVEL  = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inta_n,
  input  logic       req_valid,
  input  logic [2:0] req_level,
  input  logic       upm,
  input  logic       aeoi,
  input  logic       adi,
  input  logic [4:0] t_base,
  input  logic [2:0] addr_lo,
  input  logic [7:0] addr_hi,
  output logic       int_o,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       isr_set,
  output logic       irr_clr,
  output logic       eoi_pulse,
  output logic [2:0] isr_level,
  output logic       busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_P1   = 3'd2;
  localparam logic [2:0] S_G1   = 3'd3;
  localparam logic [2:0] S_P2   = 3'd4;
  localparam logic [2:0] S_G2   = 3'd5;
  localparam logic [2:0] S_P3   = 3'd6;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic       inta_prev_q;
  logic       inta_s, fall, rise;

  logic [2:0] state_q, state_d;
  logic       int_q, int_d;
  logic [7:0] data_q, data_d;
  logic       oe_q, oe_d;
  logic       set_q, set_d;
  logic       clr_q, clr_d;
  logic       eoi_q, eoi_d;
  logic [2:0] lvl_q, lvl_d;
  logic       spur_q, spur_d;
  logic       upm_q, upm_d;
  logic       aeoi_q, aeoi_d;
  logic       adi_q, adi_d;
  logic [4:0] t_base_q, t_base_d;
  logic [2:0] addr_lo_q, addr_lo_d;
  logic [7:0] addr_hi_q, addr_hi_d;

  assign inta_s = sync_q[SYNC_STAGES-1];
  assign fall   = inta_prev_q & ~inta_s;
  assign rise   = ~inta_prev_q & inta_s;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], inta_n};
    state_d   = state_q;
    int_d     = int_q;
    data_d    = data_q;
    oe_d      = oe_q;
    set_d     = 1'b0;
    clr_d     = 1'b0;
    eoi_d     = 1'b0;
    lvl_d     = lvl_q;
    spur_d    = spur_q;
    upm_d     = upm_q;
    aeoi_d    = aeoi_q;
    adi_d     = adi_q;
    t_base_d  = t_base_q;
    addr_lo_d = addr_lo_q;
    addr_hi_d = addr_hi_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_REQ;
        int_d   = 1'b1;
      end
      S_REQ: if (fall) begin
        // Config is frozen here so later register writes cannot corrupt the bytes.
        upm_d     = upm;
        aeoi_d    = aeoi;
        adi_d     = adi;
        t_base_d  = t_base;
        addr_lo_d = addr_lo;
        addr_hi_d = addr_hi;
        int_d     = 1'b0;
        state_d   = S_P1;
        if (req_valid) begin
          lvl_d  = req_level;
          set_d  = 1'b1;
          clr_d  = 1'b1;
          spur_d = 1'b0;
        end else begin
          lvl_d  = SPUR_LEVEL;
          spur_d = 1'b1;
        end
        if (!upm) begin
          data_d = 8'hCD;
          oe_d   = 1'b1;
        end
      end
      S_P1: if (rise) begin
        oe_d    = 1'b0;
        state_d = S_G1;
      end
      S_G1: if (fall) begin
        state_d = S_P2;
        oe_d    = 1'b1;
        if (upm_q)      data_d = {t_base_q, lvl_q};
        else if (adi_q) data_d = {addr_lo_q, lvl_q, 2'b00};
        else            data_d = {addr_lo_q[2:1], lvl_q, 3'b000};
      end
      S_P2: if (rise) begin
        oe_d = 1'b0;
        if (upm_q) begin
          state_d = S_IDLE;
          eoi_d   = aeoi_q & ~spur_q;
        end else begin
          state_d = S_G2;
        end
      end
      S_G2: if (fall) begin
        state_d = S_P3;
        data_d  = addr_hi_q;
        oe_d    = 1'b1;
      end
      S_P3: if (rise) begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
        eoi_d   = aeoi_q & ~spur_q;
      end
      default: begin
        state_d = S_IDLE;
        int_d   = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '1;
      inta_prev_q <= 1'b1;
      state_q     <= S_IDLE;
      int_q       <= 1'b0;
      data_q      <= 8'h00;
      oe_q        <= 1'b0;
      set_q       <= 1'b0;
      clr_q       <= 1'b0;
      eoi_q       <= 1'b0;
      lvl_q       <= 3'd0;
      spur_q      <= 1'b0;
      upm_q       <= 1'b0;
      aeoi_q      <= 1'b0;
      adi_q       <= 1'b0;
      t_base_q    <= 5'd0;
      addr_lo_q   <= 3'd0;
      addr_hi_q   <= 8'h00;
    end else begin
      sync_q      <= sync_d;
      inta_prev_q <= inta_s;
      state_q     <= state_d;
      int_q       <= int_d;
      data_q      <= data_d;
      oe_q        <= oe_d;
      set_q       <= set_d;
      clr_q       <= clr_d;
      eoi_q       <= eoi_d;
      lvl_q       <= lvl_d;
      spur_q      <= spur_d;
      upm_q       <= upm_d;
      aeoi_q      <= aeoi_d;
      adi_q       <= adi_d;
      t_base_q    <= t_base_d;
      addr_lo_q   <= addr_lo_d;
      addr_hi_q   <= addr_hi_d;
    end
  end

  assign int_o     = int_q;
  assign data_out  = data_q;
  assign data_oe   = oe_q;
  assign isr_set   = set_q;
  assign irr_clr   = clr_q;
  assign eoi_pulse = eoi_q;
  assign isr_level = lvl_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: 8086/8080 sequences, AEOI, spurious, reset abort.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       inta_n;
  logic       req_valid;
  logic [2:0] req_level;
  logic       upm, aeoi, adi;
  logic [4:0] t_base;
  logic [2:0] addr_lo;
  logic [7:0] addr_hi;
  logic       int_o, data_oe, isr_set, irr_clr, eoi_pulse, busy;
  logic [7:0] data_out;
  logic [2:0] isr_level;

  int checks = 0;
  int errors = 0;
  int cnt_set = 0, cnt_clr = 0, cnt_eoi = 0;

  pic_inta_sequencer #(.SYNC_STAGES(2), .SPUR_LEVEL(3'd7)) dut (
    .clk(clk), .reset(reset), .inta_n(inta_n), .req_valid(req_valid),
    .req_level(req_level), .upm(upm), .aeoi(aeoi), .adi(adi), .t_base(t_base),
    .addr_lo(addr_lo), .addr_hi(addr_hi), .int_o(int_o), .data_out(data_out),
    .data_oe(data_oe), .isr_set(isr_set), .irr_clr(irr_clr), .eoi_pulse(eoi_pulse),
    .isr_level(isr_level), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (isr_set)   cnt_set <= cnt_set + 1;
    if (irr_clr)   cnt_clr <= cnt_clr + 1;
    if (eoi_pulse) cnt_eoi <= cnt_eoi + 1;
  end

  task automatic clear_counts();
    @(negedge clk);
    cnt_set = 0;
    cnt_clr = 0;
    cnt_eoi = 0;
  endtask

  // Called at a negedge; one INTA pulse, capturing outputs after the fall and after the rise.
  task automatic inta_pulse(output logic oe_f, output logic [7:0] d_f, output logic set_f,
                            output logic [2:0] lvl_f, output logic int_f,
                            output logic oe_r, output logic eoi_r);
    inta_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    oe_f  = data_oe;
    d_f   = data_out;
    set_f = isr_set;
    lvl_f = isr_level;
    int_f = int_o;
    repeat (2) @(negedge clk);
    inta_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    oe_r  = data_oe;
    eoi_r = eoi_pulse;
    repeat (2) @(negedge clk);
  endtask

  task automatic raise_request(input logic [2:0] lvl, input string name);
    @(negedge clk);
    req_level = lvl;
    req_valid = 1'b1;
    checks++;
    if (int_o !== 1'b0) begin
      errors++;
      $display("FAIL %s int_before: got %b want 0", name, int_o);
    end
    @(negedge clk);
    checks++;
    if (int_o !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s int_rise: int_o=%b busy=%b want 1 1", name, int_o, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; inta_n = 1'b1; req_valid = 1'b0; req_level = 3'd0;
    upm = 1'b0; aeoi = 1'b0; adi = 1'b0; t_base = 5'd0; addr_lo = 3'd0; addr_hi = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({int_o, data_out, data_oe, isr_set, irr_clr, eoi_pulse, isr_level, busy} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {int_o, data_out, data_oe, isr_set, irr_clr, eoi_pulse, isr_level, busy});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8086_basic();
    logic oe_f, set_f, int_f, oe_r, eoi_r;
    logic [7:0] d_f;
    logic [2:0] lvl_f;
    upm = 1'b1; aeoi = 1'b0; t_base = 5'h11;
    clear_counts();
    raise_request(3'd3, "x86");
    inta_pulse(oe_f, d_f, set_f, lvl_f, int_f, oe_r, eoi_r);
    req_valid = 1'b0;
    checks++;
    if (set_f !== 1'b1 || lvl_f !== 3'd3 || int_f !== 1'b0 || oe_f !== 1'b0) begin
      errors++;
      $display("FAIL x86_fall1: set=%b lvl=%0d int=%b oe=%b want 1 3 0 0", set_f, lvl_f, int_f, oe_f);
    end
    inta_pulse(oe_f, d_f, set_f, lvl_f, int_f, oe_r, eoi_r);
    checks++;
    if (oe_f !== 1'b1 || d_f !== 8'h8B) begin
      errors++;
      $display("FAIL x86_vector: oe=%b data=%h want 1 8b", oe_f, d_f);
    end
    checks++;
    if (oe_r !== 1'b0 || busy !== 1'b0 || cnt_eoi !== 0 || cnt_set !== 1 || cnt_clr !== 1) begin
      errors++;
      $display("FAIL x86_end: oe=%b busy=%b eoi=%0d set=%0d clr=%0d want 0 0 0 1 1",
               oe_r, busy, cnt_eoi, cnt_set, cnt_clr);
    end
  endtask

  task automatic run_8080(input logic a_di, input logic [2:0] a_lo, input logic [7:0] a_hi,
                          input logic [2:0] lvl, input logic [7:0] exp_b2, input string name);
    logic oe_f, set_f, int_f, oe_r, eoi_r;
    logic [7:0] d_f;
    logic [2:0] lvl_f;
    upm = 1'b0; aeoi = 1'b1; adi = a_di; addr_lo = a_lo; addr_hi = a_hi;
    clear_counts();
    raise_request(lvl, name);
    inta_pulse(oe_f, d_f, set_f, lvl_f, int_f, oe_r, eoi_r);
    req_valid = 1'b0;
    // Config changes after the first fall must not affect the sequence
    upm = 1'b1; adi = ~a_di; addr_lo = ~a_lo; addr_hi = 8'hFF; aeoi = 1'b0;
    checks++;
    if (oe_f !== 1'b1 || d_f !== 8'hCD || set_f !== 1'b1 || lvl_f !== lvl || oe_r !== 1'b0) begin
      errors++;
      $display("FAIL %s byte1: oe=%b data=%h set=%b lvl=%0d oe_after=%b want 1 cd 1 %0d 0",
               name, oe_f, d_f, set_f, lvl_f, oe_r, lvl);
    end
    inta_pulse(oe_f, d_f, set_f, lvl_f, int_f, oe_r, eoi_r);
    checks++;
    if (oe_f !== 1'b1 || d_f !== exp_b2 || oe_r !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s byte2: oe=%b data=%h oe_after=%b busy=%b want 1 %h 0 1",
               name, oe_f, d_f, oe_r, busy, exp_b2);
    end
    inta_pulse(oe_f, d_f, set_f, lvl_f, int_f, oe_r, eoi_r);
    checks++;
    if (oe_f !== 1'b1 || d_f !== a_hi || oe_r !== 1'b0 || eoi_r !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s byte3: oe=%b data=%h oe_after=%b eoi=%b busy=%b want 1 %h 0 1 0",
               name, oe_f, d_f, oe_r, eoi_r, busy, a_hi);
    end
    checks++;
    if (cnt_set !== 1 || cnt_clr !== 1 || cnt_eoi !== 1) begin
      errors++;
      $display("FAIL %s pulse_counts: set=%0d clr=%0d eoi=%0d want 1 1 1", name, cnt_set, cnt_clr, cnt_eoi);
    end
  endtask

  task automatic test_8080_adi1();
    run_8080(1'b1, 3'b101, 8'h40, 3'd6, 8'hB8, "i80_adi1");
  endtask

  task automatic test_8080_adi0();
    run_8080(1'b0, 3'b110, 8'h40, 3'd2, 8'hD0, "i80_adi0");
  endtask

  task automatic test_aeoi();
    logic oe_f, set_f, int_f, oe_r, eoi_r;
    logic [7:0] d_f;
    logic [2:0] lvl_f;
    upm = 1'b1; aeoi = 1'b1; t_base = 5'h02;
    clear_counts();
    raise_request(3'd5, "aeoi");
    inta_pulse(oe_f, d_f, set_f, lvl_f, int_f, oe_r, eoi_r);
    req_valid = 1'b0;
    checks++;
    if (eoi_r !== 1'b0) begin
      errors++;
      $display("FAIL aeoi_early: eoi=%b want 0", eoi_r);
    end
    inta_pulse(oe_f, d_f, set_f, lvl_f, int_f, oe_r, eoi_r);
    checks++;
    if (eoi_r !== 1'b1 || d_f !== 8'h15 || cnt_eoi !== 1 || isr_level !== 3'd5) begin
      errors++;
      $display("FAIL aeoi_pulse: eoi=%b data=%h count=%0d lvl=%0d want 1 15 1 5",
               eoi_r, d_f, cnt_eoi, isr_level);
    end
  endtask

  task automatic test_spurious();
    logic oe_f, set_f, int_f, oe_r, eoi_r;
    logic [7:0] d_f;
    logic [2:0] lvl_f;
    upm = 1'b1; aeoi = 1'b1; t_base = 5'h0A;
    clear_counts();
    raise_request(3'd1, "spur");
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (int_o !== 1'b1) begin
      errors++;
      $display("FAIL spur_int_held: int_o=%b want 1", int_o);
    end
    inta_pulse(oe_f, d_f, set_f, lvl_f, int_f, oe_r, eoi_r);
    checks++;
    if (lvl_f !== 3'd7 || set_f !== 1'b0 || int_f !== 1'b0) begin
      errors++;
      $display("FAIL spur_fall: lvl=%0d set=%b int=%b want 7 0 0", lvl_f, set_f, int_f);
    end
    inta_pulse(oe_f, d_f, set_f, lvl_f, int_f, oe_r, eoi_r);
    checks++;
    if (d_f !== 8'h57 || oe_f !== 1'b1 || eoi_r !== 1'b0) begin
      errors++;
      $display("FAIL spur_vector: data=%h oe=%b eoi=%b want 57 1 0", d_f, oe_f, eoi_r);
    end
    checks++;
    if (cnt_set !== 0 || cnt_clr !== 0 || cnt_eoi !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL spur_counts: set=%0d clr=%0d eoi=%0d busy=%b want 0 0 0 0",
               cnt_set, cnt_clr, cnt_eoi, busy);
    end
  endtask

  task automatic test_reset_abort();
    logic oe_f, set_f, int_f, oe_r, eoi_r;
    logic [7:0] d_f;
    logic [2:0] lvl_f;
    upm = 1'b0; aeoi = 1'b1; adi = 1'b1; addr_lo = 3'b011; addr_hi = 8'h77;
    raise_request(3'd4, "abort");
    inta_pulse(oe_f, d_f, set_f, lvl_f, int_f, oe_r, eoi_r);
    req_valid = 1'b0;
    clear_counts();
    inta_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (data_oe !== 1'b1 || data_out !== 8'h70) begin
      errors++;
      $display("FAIL abort_in_p2: oe=%b data=%h want 1 70", data_oe, data_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({int_o, data_out, data_oe, isr_set, irr_clr, eoi_pulse, isr_level, busy} !== 17'd0) begin
      errors++;
      $display("FAIL abort_async: got %h want 0",
               {int_o, data_out, data_oe, isr_set, irr_clr, eoi_pulse, isr_level, busy});
    end
    inta_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_set !== 0 || cnt_eoi !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: set=%0d eoi=%0d busy=%b want 0 0 0", cnt_set, cnt_eoi, busy);
    end
    run_8080(1'b1, 3'b001, 8'h12, 3'd4, 8'h30, "after_abort");
  endtask

  initial begin
    test_reset();
    test_8086_basic();
    test_8080_adi1();
    test_8080_adi0();
    test_aeoi();
    test_spurious();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
